// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 16-bit, 8-register pipelined MIPS
//   core. It produces the enable and flush/bubble controls for PC, IF/ID,
//   ID/EX and EX/MEM. Those registers latch on negedge clk, so the controls
//   are Mealy: they are decoded from the current state and the live hazard
//   inputs, and they settle during the high phase. State, statistics and the
//   memory-wait watchdog update on posedge clk.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt        source registers of the instruction in ID
//   ex_memRead, ex_rt               load in EX and its destination register
//   mem_branch_taken                taken branch resolved in MEM
//   mem_busy                        data memory not ready this cycle
//   halt_req                        stop fetching
//   pc_en, pc_sel_target            PC enable and branch-target select
//   if_id_en/flush, id_ex_en/bubble, ex_mem_en/flush   stage controls
//   state                           0 DRAIN, 1 RUN, 2 MEM_WAIT, 3 HALT
//   stall_cnt, flush_cnt            saturating statistics
//   timeout_err                     sticky memory-wait watchdog flag
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_WAIT     = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memRead,
    input  logic [2:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             pc_sel_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_DRAIN    = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);

    state_t          state_q;
    logic [DW-1:0]   drain_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_memRead && (ex_rt != 3'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign state = state_q;

    // Mealy stage controls.
    always_comb begin
        pc_en         = 1'b1;
        pc_sel_target = 1'b0;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_flush  = 1'b0;
        unique case (state_q)
            S_DRAIN: begin
                pc_en        = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
            end
            S_RUN: begin
                if (halt_req) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                end else if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end else if (mem_branch_taken) begin
                    // The flushed ID instruction makes any load-use stall moot.
                    pc_sel_target = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_bubble  = 1'b1;
                    ex_mem_flush  = 1'b1;
                end else if (load_use) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // Once memory is ready the pipeline resumes in this same cycle.
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end
            end
            S_HALT: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, watchdog and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DRAIN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state_q)
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt <= '0;
                        state_q   <= S_RUN;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        state_q <= S_HALT;
                    end else if (mem_busy) begin
                        state_q   <= S_MEM_WAIT;
                        wait_cnt  <= WW'(1);
                        stall_cnt <= sat_inc(stall_cnt);
                    end else if (mem_branch_taken) begin
                        flush_cnt <= sat_inc(flush_cnt);
                    end else if (load_use) begin
                        stall_cnt <= sat_inc(stall_cnt);
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_busy) begin
                        stall_cnt <= sat_inc(stall_cnt);
                        wait_cnt  <= wait_cnt + WW'(1);
                        // The count is about to reach MAX_WAIT with memory still busy.
                        if (wait_cnt >= WAIT_LAST) begin
                            timeout_err <= 1'b1;
                            state_q     <= S_HALT;
                        end
                    end else begin
                        wait_cnt <= '0;
                        state_q  <= S_RUN;
                    end
                end
                S_HALT: ;
                default: state_q <= S_DRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_memRead, mem_branch_taken, mem_busy, halt_req;
    logic        pc_en, pc_sel_target, if_id_en, if_id_flush;
    logic        id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // {pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_flush}
    localparam logic [7:0] C_RUN   = 8'hAA;
    localparam logic [7:0] C_DRAIN = 8'h3F;
    localparam logic [7:0] C_LU    = 8'h0E;
    localparam logic [7:0] C_BR    = 8'hFF;
    localparam logic [7:0] C_WAIT  = 8'h00;
    localparam logic [7:0] C_HREQ  = 8'h0A;
    localparam logic [7:0] C_HALT  = 8'h1A;

    logic [7:0] ctrl;
    assign ctrl = {pc_en, pc_sel_target, if_id_en, if_id_flush,
                   id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_flush};

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MAX_WAIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_en(pc_en), .pc_sel_target(pc_sel_target),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next posedge; outputs are then sampled mid high phase.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 3'd0; id_rt = 3'd0; id_uses_rt = 1'b0;
        ex_memRead = 1'b0; ex_rt = 3'd0;
        mem_branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        settle();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'(C_DRAIN));
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk_counts("rst");

        // Release reset mid-cycle: three drain cycles, then RUN.
        rst_n = 1'b1;
        settle();
        chk("drain0_ctrl", 32'(ctrl), 32'(C_DRAIN));
        tick();
        chk("drain1_ctrl", 32'(ctrl), 32'(C_DRAIN));
        chk("drain1_state", 32'(state), 32'd0);
        tick();
        chk("drain2_ctrl", 32'(ctrl), 32'(C_DRAIN));
        tick();
        chk("run_state", 32'(state), 32'd1);
        chk("run_ctrl", 32'(ctrl), 32'(C_RUN));

        // Load-use on rs.
        ex_memRead = 1'b1; ex_rt = 3'd3; id_rs = 3'd3;
        settle();
        chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        exp_stall = 1;
        clear_inputs();
        settle();
        chk("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
        chk_counts("lu_rs");

        // r0 destination never stalls.
        ex_memRead = 1'b1; ex_rt = 3'd0; id_rs = 3'd0;
        settle();
        chk("lu_r0_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        chk_counts("lu_r0");

        // Load-use on rt only when rt is a source.
        ex_memRead = 1'b1; ex_rt = 3'd5; id_rs = 3'd1; id_rt = 3'd5; id_uses_rt = 1'b1;
        settle();
        chk("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        exp_stall = 2;
        id_uses_rt = 1'b0;
        settle();
        chk("lu_rt_unused_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        chk_counts("lu_rt");

        // Branch taken with a load-use hazard present: branch wins.
        clear_inputs();
        ex_memRead = 1'b1; ex_rt = 3'd3; id_rs = 3'd3; mem_branch_taken = 1'b1;
        settle();
        chk("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
        tick();
        exp_flush = 1;
        clear_inputs();
        settle();
        chk("br_state", 32'(state), 32'd1);
        chk_counts("br");

        // Memory wait of four busy cycles.
        mem_busy = 1'b1;
        settle();
        chk("mw1_ctrl", 32'(ctrl), 32'(C_WAIT));
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("mw_state", 32'(state), 32'd2);
            chk("mw_ctrl", 32'(ctrl), 32'(C_WAIT));
        end
        tick();
        exp_stall = 6;
        mem_busy = 1'b0;
        settle();
        chk("mw_rel_ctrl", 32'(ctrl), 32'(C_RUN));
        chk_counts("mw");
        tick();
        chk("mw_back_state", 32'(state), 32'd1);

        // Watchdog: busy held for 20 cycles.
        mem_busy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            settle();
            chk("wd_timeout", 32'(timeout_err), (i >= 16) ? 32'd1 : 32'd0);
            chk("wd_state", 32'(state), (i == 1) ? 32'd1 : (i <= 15) ? 32'd2 : 32'd3);
            chk("wd_ctrl", 32'(ctrl), (i <= 15) ? 32'(C_WAIT) : 32'(C_HALT));
            tick();
        end
        exp_stall = 21;
        mem_busy = 1'b0;
        settle();
        chk("wd_sticky", 32'(timeout_err), 32'd1);
        chk("wd_halt_ctrl", 32'(ctrl), 32'(C_HALT));
        chk_counts("wd");
        tick();
        chk("wd_halt_state", 32'(state), 32'd3);

        // Async reset from HALT, then into MEM_WAIT and reset again between edges.
        rst_n = 1'b0;
        settle();
        chk("ar1_state", 32'(state), 32'd0);
        chk("ar1_timeout", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("ar1_run", 32'(state), 32'd1);
        mem_busy = 1'b1;
        tick(); tick();
        chk("ar2_pre_state", 32'(state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0; exp_flush = 0;
        chk("ar2_state", 32'(state), 32'd0);
        chk("ar2_ctrl", 32'(ctrl), 32'(C_DRAIN));
        chk_counts("ar2");
        mem_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("ar2_run", 32'(state), 32'd1);

        // Halt request outranks memory busy.
        halt_req = 1'b1; mem_busy = 1'b1;
        settle();
        chk("hreq_ctrl", 32'(ctrl), 32'(C_HREQ));
        tick();
        clear_inputs();
        settle();
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_ctrl", 32'(ctrl), 32'(C_HALT));
        chk_counts("halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
